// File: rtl/crc_pkg.sv
// Shared types and helpers for the framed CRC engine: FSM states, bit reflection,
// the per-bit non-augmented CRC update and the IN_NBITS width helper.
package crc_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int unsigned nbits_w(input int unsigned data_w);
        return $clog2(data_w + 1);
    endfunction

    // Reverse the low n bits of v; bits at and above n come back as zero.
    function automatic logic [MAX_W-1:0] reflect_n(input logic [MAX_W-1:0] v,
                                                   input int unsigned     n);
        logic [MAX_W-1:0] r;
        logic [MAX_W-1:0] s;
        r = '0;
        s = v;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < n) begin
                r = {r[MAX_W-2:0], s[0]};
                s = s >> 1;
            end
        end
        return r;
    endfunction

    // One message bit into an n-bit remainder.
    function automatic logic [MAX_W-1:0] crc_bit_step(input logic [MAX_W-1:0] crc,
                                                      input logic             b,
                                                      input logic [MAX_W-1:0] poly,
                                                      input int unsigned      n);
        logic [MAX_W-1:0] mask;
        logic             fb;
        mask = (n >= MAX_W) ? '1 : ((MAX_W'(1) << n) - MAX_W'(1));
        fb   = (|(crc & (MAX_W'(1) << (n - 1)))) ^ b;
        return ((crc << 1) ^ (fb ? poly : '0)) & mask;
    endfunction

endpackage

// File: rtl/crc_frame_engine_if.sv
// Beat-input and result-output handshake bundle of crc_frame_engine.
// crc_match exists only when CRC_CHECK_EN is defined.
interface crc_frame_engine_if #(
    parameter int unsigned N_POLY = 8,
    parameter int unsigned DATA_W = 8
);
    localparam int unsigned NB_W = crc_pkg::nbits_w(DATA_W);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_first;
    logic              in_last;
    logic [NB_W-1:0]   in_nbits;
    logic              crc_valid;
    logic              crc_ready;
    logic [N_POLY-1:0] crc_out;
    logic              frame_err;
`ifdef CRC_CHECK_EN
    logic              crc_match;

    modport master (output in_valid, in_data, in_first, in_last, in_nbits, crc_ready,
                    input  in_ready, crc_valid, crc_out, frame_err, crc_match);
    modport slave  (input  in_valid, in_data, in_first, in_last, in_nbits, crc_ready,
                    output in_ready, crc_valid, crc_out, frame_err, crc_match);
`else
    modport master (output in_valid, in_data, in_first, in_last, in_nbits, crc_ready,
                    input  in_ready, crc_valid, crc_out, frame_err);
    modport slave  (input  in_valid, in_data, in_first, in_last, in_nbits, crc_ready,
                    output in_ready, crc_valid, crc_out, frame_err);
`endif
endinterface

// File: rtl/crc_frame_engine_beat_update.sv
// crc_beat_update: combinational DATA_W-bit unrolled CRC update with LAST-beat bit
// masking (IN_NBITS from the MSB end) and optional per-byte LSB-first feeding.
module crc_beat_update
    import crc_pkg::*;
#(
    parameter int unsigned     N_POLY     = 8,
    parameter logic [N_POLY-1:0] POLY     = N_POLY'('h07),
    parameter int unsigned     DATA_W     = 8,
    parameter bit              REFLECT_IN = 1'b0,
    parameter int unsigned     NB_W       = nbits_w(DATA_W)
) (
    input  logic [N_POLY-1:0] crc_in,
    input  logic [DATA_W-1:0] data,
    input  logic [NB_W-1:0]   nbits,
    input  logic              last,
    output logic [N_POLY-1:0] crc_next_c
);

    logic [DATA_W-1:0] d_ord;
    logic [DATA_W-1:0] sh;
    logic [N_POLY-1:0] c_n;
    int unsigned       cnt;

    // Reorder each byte lane so that its first-transmitted bit sits at the lane MSB.
    if (REFLECT_IN && DATA_W >= 8) begin : g_refl
        for (genvar l = 0; l < int'(DATA_W / 8); l++) begin : g_lane
            assign d_ord[DATA_W-1-8*l -: 8] =
                8'(reflect_n(MAX_W'(data[DATA_W-1-8*l -: 8]), 8));
        end
        if (DATA_W % 8 != 0) begin : g_tail
            assign d_ord[DATA_W%8-1:0] = data[DATA_W%8-1:0];
        end
    end else begin : g_plain
        assign d_ord = data;
    end

    always_comb begin
        cnt = DATA_W;
        if (last) begin
            cnt = (32'(nbits) > DATA_W) ? DATA_W : 32'(nbits);
            if (REFLECT_IN) begin
                cnt = (cnt / 8) * 8;
            end
        end
    end

    always_comb begin
        c_n = crc_in;
        sh  = d_ord;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (i < cnt) begin
                c_n = N_POLY'(crc_bit_step(MAX_W'(c_n), sh[DATA_W-1], MAX_W'(POLY), N_POLY));
            end
            sh = sh << 1;
        end
        crc_next_c = c_n;
    end

endmodule

// File: rtl/crc_frame_engine.sv
// Framed multi-bit-per-beat CRC engine: FIRST/LAST delimited frames, seed, reflection,
// final XOR, result held until accepted. Define CRC_CHECK_EN to add the residue comparator.
module crc_frame_engine
    import crc_pkg::*;
#(
    parameter int unsigned       N_POLY      = 8,
    parameter logic [N_POLY-1:0] POLY        = N_POLY'('h07),
    parameter int unsigned       DATA_W      = 8,
    parameter logic [N_POLY-1:0] SEED        = '0,
    parameter logic [N_POLY-1:0] XOR_OUT     = '0,
    parameter bit                REFLECT_IN  = 1'b0,
    parameter bit                REFLECT_OUT = 1'b0,
    parameter logic [N_POLY-1:0] RESIDUE     = '0
) (
    input  logic               clk,
    input  logic               rst,
    crc_frame_engine_if.slave  bus
);

    localparam int unsigned NB_W = nbits_w(DATA_W);

    state_t            state_q, state_d;
    logic [N_POLY-1:0] rem_q, rem_d;
    logic [N_POLY-1:0] beat_base;
    logic [N_POLY-1:0] beat_next_c;
    logic [N_POLY-1:0] refl_c;
    logic [N_POLY-1:0] finish_c;
    logic [N_POLY-1:0] crc_out_q;
    logic              in_ready_q;
    logic              crc_valid_q;
    logic              frame_err_q;
    logic              err_d;
    logic              load_result;
    logic              accept;

    assign accept    = bus.in_valid & in_ready_q;
    assign beat_base = bus.in_first ? SEED : rem_q;

    crc_beat_update #(
        .N_POLY     (N_POLY),
        .POLY       (POLY),
        .DATA_W     (DATA_W),
        .REFLECT_IN (REFLECT_IN),
        .NB_W       (NB_W)
    ) u_beat (
        .crc_in     (beat_base),
        .data       (bus.in_data),
        .nbits      (bus.in_nbits),
        .last       (bus.in_last),
        .crc_next_c (beat_next_c)
    );

    // Next state, next remainder and framing-error detection.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        err_d       = 1'b0;
        load_result = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.in_first) begin
                        rem_d = beat_next_c;
                        if (bus.in_last) begin
                            state_d     = HOLD;
                            load_result = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    rem_d = beat_next_c;
                    err_d = bus.in_first;
                    if (bus.in_last) begin
                        state_d     = HOLD;
                        load_result = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (crc_valid_q && bus.crc_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output finishing: optional reflection, then XOR_OUT.
    always_comb begin
        refl_c   = REFLECT_OUT ? N_POLY'(reflect_n(MAX_W'(rem_d), N_POLY)) : rem_d;
        finish_c = refl_c ^ XOR_OUT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rem_q       <= SEED;
            in_ready_q  <= 1'b1;
            crc_valid_q <= 1'b0;
            crc_out_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            in_ready_q  <= (state_d != HOLD);
            crc_valid_q <= (state_d == HOLD);
            frame_err_q <= err_d;
            if (load_result) begin
                crc_out_q <= finish_c;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.crc_valid = crc_valid_q;
    assign bus.crc_out   = crc_out_q;
    assign bus.frame_err = frame_err_q;

`ifdef CRC_CHECK_EN
    logic match_q;

    // Raw remainder against the good-frame residue, captured with the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
        end else if (load_result) begin
            match_q <= (rem_d == RESIDUE);
        end
    end

    assign bus.crc_match = match_q;
`endif

endmodule

// File: tb/tb_crc_frame_engine.sv
// Bench for crc_frame_engine: CRC-8, CRC-16/CCITT-FALSE and reflected CRC-32 instances
// share one handshake stream and are checked against a bit-queue reference model.
module tb_crc_frame_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    crc_frame_engine_if #(.N_POLY(8),  .DATA_W(8))  b8  ();
    crc_frame_engine_if #(.N_POLY(16), .DATA_W(16)) b16 ();
    crc_frame_engine_if #(.N_POLY(32), .DATA_W(8))  b32 ();

    crc_frame_engine #(
        .N_POLY(8), .POLY(8'h07), .DATA_W(8), .SEED(8'h00), .XOR_OUT(8'h00),
        .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .RESIDUE(8'h00)
    ) u_crc8 (.clk(clk), .rst(rst), .bus(b8));

    crc_frame_engine #(
        .N_POLY(16), .POLY(16'h1021), .DATA_W(16), .SEED(16'hFFFF), .XOR_OUT(16'h0000),
        .REFLECT_IN(1'b0), .REFLECT_OUT(1'b0), .RESIDUE(16'h0000)
    ) u_crc16 (.clk(clk), .rst(rst), .bus(b16));

    crc_frame_engine #(
        .N_POLY(32), .POLY(32'h04C11DB7), .DATA_W(8), .SEED(32'hFFFFFFFF),
        .XOR_OUT(32'hFFFFFFFF), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1), .RESIDUE(32'h0)
    ) u_crc32 (.clk(clk), .rst(rst), .bus(b32));

    // Message bits in transmission order, per instance.
    bit q8[$];
    bit q16[$];
    bit q32[$];
    bit in_frame = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] crc_model(input int n, input logic [63:0] poly,
                                              input logic [63:0] seed, input bit bits[$]);
        logic [63:0] crc;
        logic [63:0] mask;
        bit          fb;
        mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        crc  = seed;
        foreach (bits[i]) begin
            fb  = crc[6'(n - 1)] ^ bits[i];
            crc = ((crc << 1) ^ (fb ? poly : 64'd0)) & mask;
        end
        return crc;
    endfunction

    function automatic logic [63:0] bit_rev(input logic [63:0] v, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[6'(n - 1 - i)] = v[6'(i)];
        return r;
    endfunction

    task automatic beat(input logic [7:0] d8, input logic [15:0] d16, input bit f,
                        input bit l, input logic [3:0] n8, input logic [4:0] n16,
                        input int gap);
        int  w;
        int  c8;
        int  c16;
        int  c32;
        bit  stray;
        repeat (gap) @(negedge clk);
        b8.in_data  = d8;  b32.in_data  = d8;  b16.in_data  = d16;
        b8.in_nbits = n8;  b32.in_nbits = n8;  b16.in_nbits = n16;
        b8.in_first = f;   b16.in_first = f;   b32.in_first = f;
        b8.in_last  = l;   b16.in_last  = l;   b32.in_last  = l;
        b8.in_valid = 1'b1; b16.in_valid = 1'b1; b32.in_valid = 1'b1;
        w = 0;
        while (!b8.in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) check("ready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        b8.in_valid = 1'b0; b16.in_valid = 1'b0; b32.in_valid = 1'b0;
        stray = !f && !in_frame;
        check("frame_err8",  64'(b8.frame_err),  64'(stray || (f && in_frame)));
        check("frame_err16", 64'(b16.frame_err), 64'(stray || (f && in_frame)));
        if (!stray) begin
            if (f) begin
                q8.delete(); q16.delete(); q32.delete();
            end
            c8  = l ? ((n8 > 4'd8) ? 8 : int'(n8)) : 8;
            c16 = l ? ((n16 > 5'd16) ? 16 : int'(n16)) : 16;
            c32 = (c8 / 8) * 8;
            for (int i = 0; i < c8; i++)  q8.push_back(d8[3'(7 - i)]);
            for (int i = 0; i < c32; i++) q32.push_back(d8[3'(i)]);
            for (int i = 0; i < c16; i++) q16.push_back(d16[4'(15 - i)]);
            in_frame = !l;
        end
    endtask

    // Called at the negedge right after the LAST beat was accepted.
    task automatic result(input int hold);
        logic [63:0] r8, r16, r32, e8, e16, e32;
        r8  = crc_model(8,  64'h07,       64'h00,       q8);
        r16 = crc_model(16, 64'h1021,     64'hFFFF,     q16);
        r32 = crc_model(32, 64'h04C11DB7, 64'hFFFFFFFF, q32);
        e8  = r8;
        e16 = r16;
        e32 = bit_rev(r32, 32) ^ 64'hFFFFFFFF;
        check("valid_latency8",  64'(b8.crc_valid),  64'd1);
        check("valid_latency16", 64'(b16.crc_valid), 64'd1);
        check("valid_latency32", 64'(b32.crc_valid), 64'd1);
        for (int k = 0; k <= hold; k++) begin
            check("crc8",  64'(b8.crc_out),  e8);
            check("crc16", 64'(b16.crc_out), e16);
            check("crc32", 64'(b32.crc_out), e32);
            check("hold_ready", 64'(b8.in_ready), 64'd0);
            check("hold_valid", 64'(b8.crc_valid), 64'd1);
`ifdef CRC_CHECK_EN
            check("match8",  64'(b8.crc_match),  64'(r8 == 64'h0));
            check("match16", 64'(b16.crc_match), 64'(r16 == 64'h0));
            check("match32", 64'(b32.crc_match), 64'(r32 == 64'h0));
`endif
            if (k < hold) @(negedge clk);
        end
        b8.crc_ready = 1'b1; b16.crc_ready = 1'b1; b32.crc_ready = 1'b1;
        @(negedge clk);
        b8.crc_ready = 1'b0; b16.crc_ready = 1'b0; b32.crc_ready = 1'b0;
        check("valid_drop", 64'(b8.crc_valid | b16.crc_valid | b32.crc_valid), 64'd0);
        check("ready_back", 64'(b8.in_ready), 64'd1);
    endtask

    task automatic frame_123456789(input logic [7:0] extra, input bit add_extra);
        logic [7:0] msg[9];
        msg = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        for (int i = 0; i < 9; i++)
            beat(msg[i], 16'($urandom), i == 0, (i == 8) && !add_extra, 4'd8,
                 5'($urandom), 0);
        if (add_extra) beat(extra, 16'($urandom), 1'b0, 1'b1, 4'd8, 5'($urandom), 0);
    endtask

    initial begin
        logic [7:0] v16hi[5];
        logic [7:0] v16lo[5];
        int         len;
        b8.in_valid = 1'b0; b16.in_valid = 1'b0; b32.in_valid = 1'b0;
        b8.in_data = '0; b16.in_data = '0; b32.in_data = '0;
        b8.in_first = 1'b0; b16.in_first = 1'b0; b32.in_first = 1'b0;
        b8.in_last = 1'b0; b16.in_last = 1'b0; b32.in_last = 1'b0;
        b8.in_nbits = '0; b16.in_nbits = '0; b32.in_nbits = '0;
        b8.crc_ready = 1'b0; b16.crc_ready = 1'b0; b32.crc_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_ready", 64'(b8.in_ready & b16.in_ready & b32.in_ready), 64'd1);
        check("rst_valid", 64'(b8.crc_valid | b16.crc_valid | b32.crc_valid), 64'd0);
        check("rst_out",   64'(b32.crc_out), 64'd0);
        check("rst_err",   64'(b8.frame_err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Known vectors; result held 5 cycles before acceptance.
        frame_123456789(8'h00, 1'b0);
        check("vec_crc8",  64'(b8.crc_out),  64'hF4);
        check("vec_crc32", 64'(b32.crc_out), 64'hCBF43926);
        result(5);

        v16hi = '{8'h31, 8'h33, 8'h35, 8'h37, 8'h39};
        v16lo = '{8'h32, 8'h34, 8'h36, 8'h38, 8'hA5};
        for (int i = 0; i < 5; i++)
            beat(8'($urandom), {v16hi[i], v16lo[i]}, i == 0, i == 4,
                 4'($urandom_range(15)), (i == 4) ? 5'd8 : 5'd16, 0);
        check("vec_crc16", 64'(b16.crc_out), 64'h29B1);
        result(0);

        // Reset mid-frame discards the partial frame.
        for (int i = 0; i < 4; i++)
            beat(8'(8'h31 + i), 16'($urandom), i == 0, 1'b0, 4'd8, 5'd16, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 64'(b8.in_ready), 64'd1);
        check("mid_rst_valid", 64'(b8.crc_valid), 64'd0);
        check("mid_rst_out",   64'(b16.crc_out), 64'd0);
        check("mid_rst_err",   64'(b8.frame_err), 64'd0);
        rst = 1'b0;
        in_frame = 1'b0;
        q8.delete(); q16.delete(); q32.delete();
        @(negedge clk);
        frame_123456789(8'h00, 1'b0);
        check("post_rst_crc8", 64'(b8.crc_out), 64'hF4);
        result(1);

        beat(8'h55, 16'h1234, 1'b0, 1'b1, 4'd8, 5'd16, 1);
        check("stray_novalid", 64'(b8.crc_valid), 64'd0);
        @(negedge clk);
        check("err_pulse_end", 64'(b8.frame_err), 64'd0);

`ifdef CRC_CHECK_EN
        frame_123456789(8'hF4, 1'b1);
        check("vec_match_good", 64'(b8.crc_match), 64'd1);
        result(0);
        frame_123456789(8'hF5, 1'b1);
        check("vec_match_bad", 64'(b8.crc_match), 64'd0);
        result(0);
`endif

        // Randomized frames with gaps, stray beats, restarts and partial last beats.
        for (int fr = 0; fr < 60; fr++) begin
            if ($urandom_range(5) == 0) begin
                beat(8'($urandom), 16'($urandom), 1'b0, 1'($urandom_range(1)),
                     4'($urandom_range(15)), 5'($urandom_range(31)), $urandom_range(2));
                check("stray_novalid_r", 64'(b8.crc_valid), 64'd0);
            end
            if ($urandom_range(4) == 0) begin
                len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++)
                    beat(8'($urandom), 16'($urandom), i == 0, 1'b0, 4'($urandom),
                         5'($urandom), $urandom_range(1));
            end
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++)
                beat(8'($urandom), 16'($urandom), i == 0, i == len - 1,
                     4'($urandom_range(15)), 5'($urandom_range(31)), $urandom_range(2));
            result($urandom_range(4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
